regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-back arbiter in front of the 32x32 register file's single write port.
//  Merges in-order pipeline write-backs with out-of-order results from
//  long-latency units (mul/div), which are buffered in a small FIFO.
//  Drives registered WE/W/Din into the register file.
//  Exports a pending-write scoreboard so decode can stall on RAW/WAW hazards.
// PARAMETERS
//  DATA_WIDTH  32  write data width
//  ADDR_WIDTH  5   register address width (2**ADDR_WIDTH registers)
//  DEPTH       4   long-latency result FIFO entries (power of 2, >=2)
//  STARVE_MAX  8   cycles a FIFO head may wait before the FIFO is forced a grant
// PORTS
//  Clk        in   1                 clock, all state on posedge
//  Rst_n      in   1                 synchronous reset, active-low
//  P_WE       in   1                 pipeline write-back valid
//  P_W        in   ADDR_WIDTH        pipeline destination register
//  P_Din      in   DATA_WIDTH        pipeline write data
//  L_Valid    in   1                 long-latency result valid
//  L_W        in   ADDR_WIDTH        long-latency destination register
//  L_Din      in   DATA_WIDTH        long-latency result data
//  L_Ready    out  1                 FIFO can accept (count < DEPTH)
//  Stall_Req  out  1                 pipeline must hold its write-back this cycle
//  WE         out  1                 register file write enable (registered)
//  W          out  ADDR_WIDTH        register file write address (registered)
//  Din        out  DATA_WIDTH        register file write data (registered)
//  Pend_Mask  out  2**ADDR_WIDTH     bit r=1: a buffered/in-flight write to r
// BEHAVIOUR
//  - Reset (Rst_n=0 at posedge): FIFO empty, WE=0, W=0, Din=0, Pend_Mask=0,
//    starve counter=0; Stall_Req=0, L_Ready=0 while Rst_n=0. Reset mid-operation
//    discards all buffered results; no write is issued in the reset cycle.
//  - Accept: L_Valid & L_Ready at posedge pushes {L_W,L_Din}. L_Ready uses the
//    current count only (no same-cycle pop lookahead). L_W==0 is accepted and
//    dropped (no push, no Pend bit).
//  - Grant per cycle, priority: (1) FIFO head if Stall_Req; (2) pipeline if
//    P_WE & P_W!=0; (3) FIFO head if non-empty; (4) none.
//  - Output regs load at posedge: granted {1,W,Din}, else WE=0, W/Din hold.
//    Latency: input at cycle t -> WE/W/Din at t+1 -> regfile commit at end of t+1.
//  - P_WE with P_W==0 is never forwarded (x0 stays 0).
//  - Starve counter: +1 each cycle FIFO non-empty and head not granted
//    (saturates at STARVE_MAX); 0 on head pop or FIFO empty.
//    Stall_Req = (counter==STARVE_MAX) & FIFO non-empty (combinational).
//    While Stall_Req=1 the pipeline holds P_WE/P_W/P_Din stable; the held
//    write is granted the following cycle (counter reset by the pop).
//  - Pend_Mask[r]: set at posedge of acceptance with L_W=r; cleared at posedge
//    that ends the cycle in which WE=1,W=r was driven from a FIFO pop.
//    Pipeline writes never touch Pend_Mask. Accept + clear of same r in one
//    cycle: set wins.
//  - Decode guarantees at most one outstanding long-latency write per register
//    and no pipeline write to r while Pend_Mask[r]=1; behaviour otherwise is
//    undefined (assertion in bench).
//  - Full FIFO: L_Ready=0, L_Valid held by producer; push+pop same cycle when
//    not full keeps count unchanged. Pointers wrap mod DEPTH.
// TESTING
//  1 Reset: Rst_n=0 2 cycles with P_WE=1,L_Valid=1 -> WE=0,Pend_Mask=0,L_Ready=0;
//    release -> L_Ready=1 next cycle.
//  2 Pipeline only: P_WE=1,P_W=5,P_Din=0x1234 at t -> WE=1,W=5,Din=0x1234 at t+1;
//    P_W=0 -> WE=0.
//  3 FIFO drain: push L_W=7 0xAAAA, L_W=9 0xBBBB, P_WE=0 -> WE writes r7 then r9
//    in order, Pend_Mask bits 7,9 set then cleared one cycle after each write.
//  4 Priority: FIFO holds r3 while P_WE=1 (r4) -> r4 granted first, r3 next idle cycle.
//  5 Starvation: FIFO holds r6, P_WE=1 every cycle -> Stall_Req=1 after 8 lost
//    cycles, r6 written, held pipeline write emitted next cycle, no write lost.
//  6 Full: 4 pushes, no drain (P_WE=1 continuous) -> L_Ready=0; 5th L_Valid held,
//    accepted after first pop; order r-values preserved across pointer wrap.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port: pipeline results vs. a small FIFO of long-latency results.
// Latency 1 cycle to registered WE/W/Din; L_Ready drops when FIFO full; Stall_Req forces a FIFO grant after STARVE_MAX lost cycles.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     P_WE,
    input  logic [ADDR_WIDTH-1:0]    P_W,
    input  logic [DATA_WIDTH-1:0]    P_Din,
    input  logic                     L_Valid,
    input  logic [ADDR_WIDTH-1:0]    L_W,
    input  logic [DATA_WIDTH-1:0]    L_Din,
    output logic                     L_Ready,
    output logic                     Stall_Req,
    output logic                     WE,
    output logic [ADDR_WIDTH-1:0]    W,
    output logic [DATA_WIDTH-1:0]    Din,
    output logic [2**ADDR_WIDTH-1:0] Pend_Mask
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int NREG = 2**ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] fifo_w_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] w_q, w_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [NREG-1:0]       pend_q, pend_d;
    logic                  from_fifo_q, from_fifo_d;

    logic empty, pipe_ok, pop, push;

    assign empty     = (count_q == '0);
    assign L_Ready   = Rst_n & (count_q < CW'(DEPTH));
    assign Stall_Req = Rst_n & ~empty & (starve_q == SW'(STARVE_MAX));
    // Writes to x0 are never forwarded nor buffered.
    assign pipe_ok   = P_WE & (P_W != '0);
    assign pop       = ~empty & (Stall_Req | ~pipe_ok);
    assign push      = L_Valid & L_Ready & (L_W != '0);

    always_comb begin
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        wr_ptr_d    = wr_ptr_q + PW'(push);
        count_d     = count_q + CW'(push) - CW'(pop);
        starve_d    = starve_q;
        we_d        = pop | pipe_ok;
        w_d         = w_q;
        din_d       = din_q;
        from_fifo_d = pop;
        pend_d      = pend_q;

        if (empty || pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);

        if (pop) begin
            w_d   = fifo_w_q[rd_ptr_q];
            din_d = fifo_d_q[rd_ptr_q];
        end else if (pipe_ok) begin
            w_d   = P_W;
            din_d = P_Din;
        end

        // Clear for the write committed this cycle first so a fresh accept of the same register wins.
        if (we_q && from_fifo_q)
            pend_d[w_q] = 1'b0;
        if (push)
            pend_d[L_W] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            we_q        <= 1'b0;
            w_q         <= '0;
            din_q       <= '0;
            pend_q      <= '0;
            from_fifo_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            w_q         <= w_d;
            din_q       <= din_d;
            pend_q      <= pend_d;
            from_fifo_q <= from_fifo_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_w_q[wr_ptr_q] <= L_W;
            fifo_d_q[wr_ptr_q] <= L_Din;
        end
    end

    assign WE        = we_q;
    assign W         = w_q;
    assign Din       = din_q;
    assign Pend_Mask = pend_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_regfile_wb_arbiter;
    localparam int DW = 32, AW = 5, DEPTH = 4, SMAX = 8;

    logic          Clk = 1'b0;
    logic          Rst_n, P_WE, L_Valid;
    logic [AW-1:0] P_W, L_W;
    logic [DW-1:0] P_Din, L_Din;
    logic          L_Ready, Stall_Req, WE;
    logic [AW-1:0] W;
    logic [DW-1:0] Din;
    logic [31:0]   Pend_Mask;

    always #5 Clk = ~Clk;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .P_WE(P_WE), .P_W(P_W), .P_Din(P_Din),
        .L_Valid(L_Valid), .L_W(L_W), .L_Din(L_Din), .L_Ready(L_Ready),
        .Stall_Req(Stall_Req), .WE(WE), .W(W), .Din(Din), .Pend_Mask(Pend_Mask)
    );

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [AW-1:0] w; logic [DW-1:0] d; } ent_t;

    // Reference model: FIFO as a queue, starvation as a plain integer.
    ent_t          mq[$];
    ent_t          seen[$];
    ent_t          e;
    int            starve = 0;
    bit            started = 0;
    bit            m_we = 0, m_last_fifo = 0;
    logic [AW-1:0] m_w = '0;
    logic [DW-1:0] m_din = '0;
    logic [31:0]   m_pend = '0;
    bit            mdl_pipe, mdl_stall, mdl_lrdy, mdl_pop;

    always @(posedge Clk) begin
        if (!Rst_n) begin
            mq.delete();
            starve = 0; m_we = 0; m_w = '0; m_din = '0; m_pend = '0; m_last_fifo = 0;
            started = 1;
        end else if (started) begin
            mdl_pipe  = P_WE && (P_W != 0);
            mdl_stall = (starve == SMAX) && (mq.size() > 0);
            mdl_lrdy  = mq.size() < DEPTH;
            mdl_pop   = (mq.size() > 0) && (mdl_stall || !mdl_pipe);
            if (mdl_pipe) begin
                vectors++;
                if (m_pend[P_W]) begin
                    miscompares++;
                    $display("FAIL hazard: pipeline write to pending r%0d", P_W);
                end
            end
            if (m_we && m_last_fifo) m_pend[m_w] = 1'b0;
            if (mdl_pop) begin
                e = mq.pop_front();
                m_we = 1; m_w = e.w; m_din = e.d; m_last_fifo = 1; starve = 0;
            end else begin
                m_last_fifo = 0;
                if (mdl_pipe) begin
                    m_we = 1; m_w = P_W; m_din = P_Din;
                end else begin
                    m_we = 0;
                end
                if (mq.size() > 0) starve = (starve < SMAX) ? starve + 1 : SMAX;
                else               starve = 0;
            end
            if (L_Valid && mdl_lrdy && L_W != 0) begin
                e.w = L_W; e.d = L_Din;
                mq.push_back(e);
                m_pend[L_W] = 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            chk("we", WE, m_we);
            chk("w", W, m_w);
            chk("din", Din, m_din);
            chk("pend", Pend_Mask, m_pend);
            chk("l_ready", L_Ready, Rst_n && (mq.size() < DEPTH));
            chk("stall", Stall_Req, Rst_n && (starve == SMAX) && (mq.size() > 0));
            if (WE && W >= 10 && W <= 14) begin
                e.w = W; e.d = Din;
                seen.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        miscompares++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

    initial begin
        int k, j, stall_at, held_k, accept_cyc;
        bit st, lr, full_checked;

        // Reset with active inputs
        Rst_n = 0; P_WE = 1; P_W = 3; P_Din = 32'h11; L_Valid = 1; L_W = 4; L_Din = 32'h22;
        tick(); tick();
        chk("rst_we", WE, 0);
        chk("rst_pend", Pend_Mask, 0);
        chk("rst_lready", L_Ready, 0);
        chk("rst_stall", Stall_Req, 0);
        Rst_n = 1; P_WE = 0; L_Valid = 0;
        tick();
        chk("rel_lready", L_Ready, 1);

        // Pipeline only, then x0
        P_WE = 1; P_W = 5; P_Din = 32'h1234;
        tick();
        chk("pipe_we", WE, 1); chk("pipe_w", W, 5); chk("pipe_din", Din, 32'h1234);
        P_W = 0; P_Din = 32'h9999;
        tick();
        chk("x0_we", WE, 0); chk("x0_w_hold", W, 5); chk("x0_din_hold", Din, 32'h1234);
        P_WE = 0;

        // FIFO drain in order
        L_Valid = 1; L_W = 7; L_Din = 32'hAAAA;
        tick();
        chk("drain_pend0", Pend_Mask, 32'h0000_0080);
        L_W = 9; L_Din = 32'hBBBB;
        tick();
        L_Valid = 0;
        chk("drain_w7", W, 7); chk("drain_d7", Din, 32'hAAAA); chk("drain_we1", WE, 1);
        chk("drain_pend1", Pend_Mask, 32'h0000_0280);
        tick();
        chk("drain_w9", W, 9); chk("drain_d9", Din, 32'hBBBB);
        chk("drain_pend2", Pend_Mask, 32'h0000_0200);
        tick();
        chk("drain_we_off", WE, 0); chk("drain_pend3", Pend_Mask, 0);

        // Long-latency write to x0 is accepted and dropped
        L_Valid = 1; L_W = 0; L_Din = 32'hDEAD;
        tick();
        L_Valid = 0;
        chk("lx0_pend", Pend_Mask, 0);
        tick();
        chk("lx0_we", WE, 0);

        // Pipeline has priority over a non-starved FIFO head
        L_Valid = 1; L_W = 3; L_Din = 32'h33;
        tick();
        L_Valid = 0; P_WE = 1; P_W = 4; P_Din = 32'h44;
        tick();
        chk("prio_w4", W, 4); chk("prio_d4", Din, 32'h44); chk("prio_pend", Pend_Mask, 32'h8);
        P_WE = 0;
        tick();
        chk("prio_w3", W, 3); chk("prio_d3", Din, 32'h33);
        tick();
        chk("prio_we_off", WE, 0); chk("prio_pend_clr", Pend_Mask, 0);

        // Starvation: head waits 8 lost cycles, then the held pipeline write follows
        k = 0; stall_at = -1; held_k = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            P_WE = 1; P_W = AW'(20 + k % 8); P_Din = 32'h500 + k;
            if (cyc == 0) begin L_Valid = 1; L_W = 6; L_Din = 32'h66; end
            else L_Valid = 0;
            st = Stall_Req;
            if (st && stall_at < 0) begin stall_at = cyc; held_k = k; end
            tick();
            if (!st) k++;
            if (stall_at >= 0 && cyc == stall_at) begin
                chk("starve_w6", W, 6); chk("starve_d6", Din, 32'h66);
            end
            if (stall_at >= 0 && cyc == stall_at + 1) begin
                chk("starve_held_w", W, 20 + held_k % 8);
                chk("starve_held_d", Din, 32'h500 + held_k);
            end
        end
        chk("starve_cycle", stall_at, 9);

        // Full FIFO with continuous pipeline traffic; 5th push held until after the first pop
        k = 0; j = 0; accept_cyc = -1; full_checked = 0; seen.delete();
        for (int cyc = 0; cyc < 150 && (j < 5 || seen.size() < 5); cyc++) begin
            P_WE = 1; P_W = AW'(20 + k % 8); P_Din = 32'h700 + k;
            if (j < 5) begin L_Valid = 1; L_W = AW'(10 + j); L_Din = 32'hC00 + j; end
            else L_Valid = 0;
            st = Stall_Req; lr = L_Ready;
            if (j == 4 && !full_checked) begin
                chk("full_lready", L_Ready, 0);
                full_checked = 1;
            end
            tick();
            if (!st) k++;
            if (j < 5 && lr) begin
                if (j == 4) accept_cyc = cyc;
                j++;
            end
        end
        P_WE = 0; L_Valid = 0;
        tick(); tick();
        chk("full_seen", full_checked, 1);
        chk("full_accept_cyc", accept_cyc, 10);
        chk("full_pop_count", seen.size(), 5);
        for (int i = 0; i < seen.size() && i < 5; i++) begin
            chk("full_order_w", seen[i].w, 10 + i);
            chk("full_order_d", seen[i].d, 32'hC00 + i);
        end
        chk("full_pend_end", Pend_Mask, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
